// File: rtl/array_seq_pkg.sv
// array_seq_pkg: shared types and phase-length helpers for the systolic
// array sequencer (array_seq) and its row skew line.
package array_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WLOAD   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_FIN     = 3'd4
    } seq_state_t;

    // COMPUTE must cover the base window plus the full row and column skew
    // so that the last mac_done reaches the far column.
    function automatic logic [31:0] compute_len(input logic [31:0] h,
                                                input logic [31:0] w,
                                                input logic [31:0] l);
        return l + h + w - 32'd2;
    endfunction

    // DRAIN shifts HEIGHT partial sums out of every column, with each
    // column starting one cycle after its left neighbour.
    function automatic logic [31:0] drain_len(input logic [31:0] h,
                                              input logic [31:0] w);
        return h + w - 32'd1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// skew_line: TAPS-deep shift register carrying the three base row signals
// (enable, clear, mac_done). Tap h is the base delayed by h cycles, so tap 0
// is the undelayed (but registered) base. A synchronous flush empties every
// tap so an aborted tile leaves nothing in flight.
module skew_line
    import array_seq_pkg::*;
#(
    parameter int TAPS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [2:0]      base_i,
    output logic [TAPS-1:0] en_tap_o,
    output logic [TAPS-1:0] clr_tap_o,
    output logic [TAPS-1:0] done_tap_o
);

    logic [2:0] taps_q [TAPS];

    // Shift the base signals down the rows, clearing everything on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int h = 0; h < TAPS; h++) taps_q[h] <= 3'b000;
        end else if (flush_i) begin
            for (int h = 0; h < TAPS; h++) taps_q[h] <= 3'b000;
        end else begin
            taps_q[0] <= base_i;
            for (int h = 1; h < TAPS; h++) taps_q[h] <= taps_q[h-1];
        end
    end

    // Unpack the taps into per-signal row vectors.
    always_comb begin
        en_tap_o   = '0;
        clr_tap_o  = '0;
        done_tap_o = '0;
        for (int h = 0; h < TAPS; h++) begin
            en_tap_o[h]   = taps_q[h][2];
            clr_tap_o[h]  = taps_q[h][1];
            done_tap_o[h] = taps_q[h][0];
        end
    end

endmodule

// File: rtl/array_seq.sv
// array_seq: sequencer for a HEIGHT x WIDTH rate-coded systolic MAC array.
// Runs one tile through weight load, skewed compute and output drain, and
// reports completion with a busy/done handshake. Every output is a register
// loaded from the next-state decode, so no input reaches an output
// combinationally.
// Optional feature: define ARRAY_SEQ_PERF_EN to add the perf_cycles busy-cycle
// counter output.
module array_seq
    import array_seq_pkg::*;
#(
    parameter int HEIGHT     = 4,
    parameter int WIDTH      = 4,
    parameter int MAC_CYCLES = 16,
    parameter int LWIDTH     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LWIDTH-1:0] cfg_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              w_rd,
    output logic              ifm_rd,
    output logic [HEIGHT-1:0] en_i,
    output logic [HEIGHT-1:0] clr_i,
    output logic [HEIGHT-1:0] mac_done,
    output logic [WIDTH-1:0]  en_w,
    output logic [WIDTH-1:0]  clr_w,
    output logic [WIDTH-1:0]  en_o,
    output logic [WIDTH-1:0]  clr_o
`ifdef ARRAY_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    // Phase counter must hold the longest phase (COMPUTE at maximum cfg_len).
    localparam int PW = $clog2(((2 ** LWIDTH) - 1) * MAC_CYCLES + HEIGHT + WIDTH + 1);
    localparam int MW = $clog2(MAC_CYCLES);
    localparam logic [PW-1:0] WLOAD_LAST = PW'(HEIGHT - 1);
    localparam logic [PW-1:0] DRAIN_LAST = PW'(drain_len(HEIGHT, WIDTH) - 32'd1);
    localparam logic [MW-1:0] MC_LAST    = MW'(MAC_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [MW-1:0]     mc_q, mc_d;
    logic [LWIDTH-1:0] vec_q, vec_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic [PW-1:0]     comp_last_s;

    logic              base_en_s, base_clr_s, base_done_s;
    logic              busy_d, done_d, ifm_rd_d;
    logic [WIDTH-1:0]  en_w_d, clr_w_d, en_o_d, clr_o_d;

    logic              busy_q, done_q, ifm_rd_q;
    logic [WIDTH-1:0]  en_w_q, clr_w_q, en_o_q, clr_o_q;

    // Last COMPUTE cycle index depends on the latched tile length.
    always_comb begin
        comp_last_s = PW'(compute_len(32'(HEIGHT), 32'(WIDTH),
                                      32'(len_q) * 32'(MAC_CYCLES)) - 32'd1);
    end

    // Next-state, phase counter and vector counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        vec_d   = vec_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_len != '0)) begin
                    state_d = ST_WLOAD;
                    len_d   = cfg_len;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WLOAD: begin
                if (cnt_q == WLOAD_LAST) begin
                    state_d = ST_COMPUTE;
                    cnt_d   = '0;
                    mc_d    = '0;
                    vec_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            ST_COMPUTE: begin
                if (cnt_q == comp_last_s) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
                // Vector counter stops once cfg_len vectors have streamed.
                if (vec_q != len_q) begin
                    if (mc_q == MC_LAST) begin
                        mc_d  = '0;
                        vec_d = vec_q + LWIDTH'(1);
                    end else begin
                        mc_d = mc_q + MW'(1);
                    end
                end else begin
                    mc_d  = mc_q;
                    vec_d = vec_q;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_FIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            state_d = state_d;
        end
    end

    // Decode next-cycle output values from the next state and counters.
    always_comb begin
        base_en_s   = (state_d == ST_COMPUTE) && (vec_d != len_q);
        base_clr_s  = (state_d == ST_COMPUTE) && (vec_d == '0) && (mc_d == '0);
        base_done_s = (state_d == ST_COMPUTE) && (vec_d == (len_q - LWIDTH'(1)))
                      && (mc_d == MC_LAST);
        ifm_rd_d    = base_en_s;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_FIN);
        en_w_d      = {WIDTH{state_d == ST_WLOAD}};
        clr_w_d     = {WIDTH{(state_d == ST_WLOAD) && (cnt_d == '0)}};
        en_o_d      = '0;
        clr_o_d     = '0;
        for (int w = 0; w < WIDTH; w++) begin
            en_o_d[w]  = (state_d == ST_DRAIN) && (cnt_d >= PW'(w))
                         && (cnt_d < PW'(w + HEIGHT));
            clr_o_d[w] = (state_d == ST_DRAIN) && (cnt_d == PW'(w + HEIGHT - 1));
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            vec_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            vec_q   <= vec_d;
            len_q   <= len_d;
        end
    end

    // Output registers for the unskewed controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ifm_rd_q <= 1'b0;
            en_w_q   <= '0;
            clr_w_q  <= '0;
            en_o_q   <= '0;
            clr_o_q  <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            ifm_rd_q <= ifm_rd_d;
            en_w_q   <= en_w_d;
            clr_w_q  <= clr_w_d;
            en_o_q   <= en_o_d;
            clr_o_q  <= clr_o_d;
        end
    end

    skew_line #(
        .TAPS (HEIGHT)
    ) u_skew (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (abort),
        .base_i     ({base_en_s, base_clr_s, base_done_s}),
        .en_tap_o   (en_i),
        .clr_tap_o  (clr_i),
        .done_tap_o (mac_done)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign ifm_rd = ifm_rd_q;
    assign en_w   = en_w_q;
    assign w_rd   = en_w_q[0];
    assign clr_w  = clr_w_q;
    assign en_o   = en_o_q;
    assign clr_o  = clr_o_q;

`ifdef ARRAY_SEQ_PERF_EN
    logic        accept_s;
    logic [31:0] perf_q;

    assign accept_s = (state_q == ST_IDLE) && start && (cfg_len != '0);

    // Saturating count of busy cycles, restarted by each accepted tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else if (accept_s) begin
            perf_q <= 32'd0;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_array_seq.sv
// tb_array_seq: self-checking bench for array_seq. Expected outputs come from
// a cycle-relative timing model built on the tile schedule formulas.
module tb_array_seq;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int MC = 16;
    localparam int LW = 8;
`ifdef ARRAY_SEQ_PERF_EN
    localparam int OW = 4 + 3 * H + 4 * W + 32;
`else
    localparam int OW = 4 + 3 * H + 4 * W;
`endif

    logic          clk, rst, start, abort;
    logic [LW-1:0] cfg_len;
    logic          busy, done, w_rd, ifm_rd;
    logic [H-1:0]  en_i, clr_i, mac_done;
    logic [W-1:0]  en_w, clr_w, en_o, clr_o;
`ifdef ARRAY_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    array_seq #(.HEIGHT(H), .WIDTH(W), .MAC_CYCLES(MC), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
        .busy(busy), .done(done), .w_rd(w_rd), .ifm_rd(ifm_rd),
        .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done),
        .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o)
`ifdef ARRAY_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference model: one tile in flight, described by its acceptance cycle.
    bit          m_active = 1'b0;
    int          m_t      = 0;
    int          m_len    = 0;
    logic [31:0] m_perf   = 32'd0;

    function automatic int fin_rel(int len);
        return (H + 1) + (len * MC + H + W - 2) + (H + W - 1);
    endfunction

    function automatic logic [OW-1:0] sample();
`ifdef ARRAY_SEQ_PERF_EN
        return {busy, done, w_rd, ifm_rd, en_i, clr_i, mac_done,
                en_w, clr_w, en_o, clr_o, perf_cycles};
`else
        return {busy, done, w_rd, ifm_rd, en_i, clr_i, mac_done,
                en_w, clr_w, en_o, clr_o};
`endif
    endfunction

    function automatic logic [OW-1:0] model_out(int c);
        logic b, d, wr, ir;
        logic [H-1:0] ei, ci, md;
        logic [W-1:0] ew, cw, eo, co;
        int r, l, t0, dr, fr;
        b = 0; d = 0; wr = 0; ir = 0;
        ei = '0; ci = '0; md = '0; ew = '0; cw = '0; eo = '0; co = '0;
        if (m_active) begin
            r  = c - m_t;
            l  = m_len * MC;
            t0 = H + 1;
            dr = t0 + l + H + W - 2;
            fr = dr + H + W - 1;
            if (r >= 1 && r <= fr) begin
                b  = 1;
                wr = (r >= 1 && r <= H);
                ew = {W{wr}};
                cw = {W{r == 1}};
                ir = (r >= t0 && r <= t0 + l - 1);
                for (int h = 0; h < H; h++) begin
                    ei[h] = (r >= t0 + h && r <= t0 + h + l - 1);
                    ci[h] = (r == t0 + h);
                    md[h] = (r == t0 + h + l - 1);
                end
                for (int w = 0; w < W; w++) begin
                    eo[w] = (r >= dr + w && r <= dr + w + H - 1);
                    co[w] = (r == dr + w + H - 1);
                end
                d = (r == fr);
            end
        end
`ifdef ARRAY_SEQ_PERF_EN
        return {b, d, wr, ir, ei, ci, md, ew, cw, eo, co, m_perf};
`else
        return {b, d, wr, ir, ei, ci, md, ew, cw, eo, co};
`endif
    endfunction

    // One clock cycle: sample at negedge, advance the model with this cycle's
    // inputs, then return #1 after the next posedge for new inputs.
    task automatic step(output logic [OW-1:0] obs, output logic [OW-1:0] exp);
        bit idle;
        @(negedge clk);
        obs  = sample();
        exp  = model_out(cyc);
        idle = !m_active || ((cyc - m_t) > fin_rel(m_len));
        if (idle) begin
            if (start && cfg_len != '0) begin
                m_active = 1'b1;
                m_t      = cyc;
                m_len    = int'(cfg_len);
                m_perf   = 32'd0;
            end
        end else begin
            if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
            if (abort) m_active = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs, exp;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_len = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (sample() !== '0) begin
                miscompares++;
                $display("FAIL reset_hold: got %h want 0", sample());
            end
        end
        rst = 1'b0;
        cyc = 0; m_active = 1'b0; m_perf = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, obs, exp);
            end
        end
    endtask

    task automatic test_nominal();
        logic [OW-1:0] obs, exp;
        int done_at = -1;
        int busy_cnt = 0;
        start = 1'b1; cfg_len = 8'd2;
        for (int i = 0; i < 60; i++) begin
            if (i == 1) begin start = 1'b0; cfg_len = 8'd0; end
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL nominal rel %0d: got %h want %h", i, obs, exp);
            end
            if (obs[OW-2]) done_at = i;
            if (obs[OW-1]) busy_cnt++;
        end
        vectors++;
        if (done_at !== 50) begin
            miscompares++;
            $display("FAIL nominal_done_cycle: got %0d want 50", done_at);
        end
        vectors++;
        if (busy_cnt !== 50) begin
            miscompares++;
            $display("FAIL nominal_busy_len: got %0d want 50", busy_cnt);
        end
`ifdef ARRAY_SEQ_PERF_EN
        vectors++;
        if (perf_cycles !== 32'd50) begin
            miscompares++;
            $display("FAIL perf_nominal: got %0d want 50", perf_cycles);
        end
`endif
    endtask

    task automatic test_zero_len();
        logic [OW-1:0] obs, exp;
        start = 1'b1; cfg_len = 8'd0;
        for (int i = 0; i < 6; i++) begin
            step(obs, exp);
            vectors++;
            if (obs !== exp || obs[OW-1] !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_len rel %0d: got %h want %h", i, obs, exp);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        logic [OW-1:0] obs, exp;
        start = 1'b1; cfg_len = 8'd2;
        for (int i = 0; i < 95; i++) begin
            start = (i == 0 || i == 21);
            cfg_len = (i == 21) ? 8'd3 : 8'd2;
            abort = (i == 20);
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL abort rel %0d: got %h want %h", i, obs, exp);
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [OW-1:0] obs, exp;
        start = 1'b1; cfg_len = 8'd1;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) start = 1'b0;
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL async_pre rel %0d: got %h want %h", i, obs, exp);
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (sample() !== '0) begin
            miscompares++;
            $display("FAIL async_reset_now: got %h want 0", sample());
        end
        rst = 1'b0;
        m_active = 1'b0; m_perf = 32'd0;
        for (int i = 0; i < 30; i++) begin
            start = (i == 3); cfg_len = 8'd1;
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL async_post rel %0d: got %h want %h", i, obs, exp);
            end
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) step(obs, exp);
    endtask

    task automatic test_back_to_back();
        logic [OW-1:0] obs, exp;
        int dones = 0;
        int first_done = -1;
        start = 1'b1; cfg_len = 8'd1;
        for (int i = 0; i < 80; i++) begin
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL b2b rel %0d: got %h want %h", i, obs, exp);
            end
            if (obs[OW-2]) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
        end
        vectors++;
        if (dones !== 2 || first_done !== 34) begin
            miscompares++;
            $display("FAIL b2b_dones: got %0d first %0d want 2 first 34", dones, first_done);
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) step(obs, exp);
    endtask

    task automatic test_random();
        logic [OW-1:0] obs, exp;
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 3) == 0);
            cfg_len = LW'($urandom_range(0, 3));
            abort   = ($urandom_range(0, 80) == 0);
            step(obs, exp);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, obs, exp);
            end
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/array_seq.md
# array_seq

Sequencer for the HEIGHT×WIDTH rate-coded systolic MAC array. It drives every array-edge control vector: per-row `en_i`/`clr_i`/`mac_done` and per-column `en_w`/`clr_w`/`en_o`/`clr_o`. It runs one tile through weight load, skewed compute and output drain, and reports completion through a start/busy/done handshake. It sits between the tile scheduler and the array, alongside the ifm/weight buffers it paces through `ifm_rd`/`w_rd`.

## Interface
- `HEIGHT`, 4, array rows.
- `WIDTH`, 4, array columns.
- `MAC_CYCLES`, 16, bitstream length per ifm vector; must be ≥ 2.
- `LWIDTH`, 8, width of `cfg_len`.
- `clk` in 1, single clock.
- `rst` in 1, asynchronous active-high reset.
- `start` in 1, start a tile; sampled in IDLE only.
- `cfg_len` in LWIDTH, number of ifm vectors accumulated per tile; sampled with `start`.
- `abort` in 1, return to IDLE next cycle.
- `busy` out 1, high from the first cycle after acceptance through the `done` cycle.
- `done` out 1, one-cycle completion pulse.
- `w_rd` out 1, weight buffer pop (mirrors `en_w[0]`).
- `ifm_rd` out 1, ifm buffer pop (high during the unskewed compute window).
- `en_i`, `clr_i`, `mac_done` out HEIGHT, row controls.
- `en_w`, `clr_w`, `en_o`, `clr_o` out WIDTH, column controls.

## Operation
- States: IDLE → WLOAD → COMPUTE → DRAIN → FIN → IDLE.
- **IDLE**
  - All outputs are 0.
  - `start`=1 with `cfg_len`≠0 latches `cfg_len` and moves to WLOAD.
  - `start` with `cfg_len`=0 is ignored; the state stays IDLE.
- **WLOAD** (HEIGHT cycles)
  - `en_w` is all-ones and `w_rd` is 1.
  - `clr_w` is all-ones on the first cycle only.
- **COMPUTE**
  - Let L = cfg_len·MAC_CYCLES and T0 = first COMPUTE cycle.
  - Base window: cycles T0 … T0+L−1. `ifm_rd` is high during the base window.
  - Row h receives the base signals delayed by h cycles:
    - `en_i[h]` high on T0+h … T0+h+L−1.
    - `clr_i[h]` high on T0+h.
    - `mac_done[h]` high on T0+h+L−1.
  - COMPUTE lasts L+HEIGHT+WIDTH−2 cycles, so the last `mac_done` reaches the far column.
- **DRAIN** (HEIGHT+WIDTH−1 cycles, starting at D)
  - `en_o[w]` high on D+w … D+w+HEIGHT−1.
  - `clr_o[w]` high on D+w+HEIGHT−1 only.
- **FIN** (1 cycle): `done`=1, then IDLE.
- `abort` in any non-IDLE state:
  - The next state is IDLE.
  - All outputs, including skew-line contents, are 0 the next cycle.
  - `done` is not pulsed.
- `start` while not IDLE is ignored.
- Counters:
  - The phase counter is wide enough for L+HEIGHT+WIDTH.
  - The vector counter counts MAC_CYCLES per vector and stops after cfg_len vectors.
  - Neither counter wraps.

## Timing
- Reset value of every output is 0; the state is IDLE.
- All outputs are registered; no combinational input→output path.
- `start` accepted at cycle t: WLOAD occupies t+1 … t+HEIGHT, so T0 = t+HEIGHT+1.
- FIN cycle = T0 + L + HEIGHT + WIDTH − 2 + HEIGHT + WIDTH − 1.
- `busy` falls the cycle after FIN; a new `start` is accepted in that cycle.
- `rst` asserted mid-operation: state and outputs go to reset values immediately (asynchronous).

## Configuration
- Macro `ARRAY_SEQ_PERF_EN`.
- Defined:
  - Adds output `perf_cycles` [31:0], counting cycles with `busy`=1.
  - Cleared on `rst` and on accepted `start`.
  - Saturates at all-ones.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `array_seq_pkg` holds:
  - the state enum typedef `seq_state_t`;
  - functions for phase lengths (`compute_len`, `drain_len`) of HEIGHT, WIDTH and L.
- Sub-module `skew_line`:
  - HEIGHT-tap shift register (tap 0 undelayed) for the three base row signals;
  - synchronous flush on `abort`.

## Test plan
Default parameters (HEIGHT=WIDTH=4, MAC_CYCLES=16) unless stated.
- **Nominal tile.** `cfg_len`=2, `start` at cycle 0:
  - `en_w`=4'b1111 on 1–4, `clr_w` on 1;
  - `en_i[0]` on 5–36, `en_i[3]` on 8–39;
  - `mac_done[3]` at 39; `ifm_rd` on 5–36;
  - `en_o[0]` on 43–46, `en_o[3]` on 46–49; `clr_o[3]` at 49;
  - `done` at 50; `busy` 1–50.
- **Zero length.** `cfg_len`=0 with `start` → no state change; `busy` stays 0.
- **Abort.** `abort` at cycle 20 of the nominal tile → all outputs 0 from cycle 21; no `done`; new `start` at 21 accepted.
- **Async reset.** `rst` pulsed mid-COMPUTE → outputs 0 in the same cycle; IDLE after release.
- **Back-to-back.** `start` held high continuously → second tile accepted at 51; `start` during busy ignored.
- **Perf counter.** `ARRAY_SEQ_PERF_EN` defined → `perf_cycles`=50 after the nominal tile.
